// File: rtl/wb_pkg.sv
// wb_pkg: shared result-select encodings, queue depth, FSM states and queue entry layout
package wb_pkg;
    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_PC2 = 2'b10;
    localparam logic [1:0] SEL_IMM = 2'b11;
    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    // wen and dst sit in the top bits so the queue can expose them as a tag
    typedef struct packed {
        logic        wen;
        logic [2:0]  dst;
        logic [15:0] data;
        logic        halt;
    } entry_t;
    localparam int ENTRY_W = $bits(entry_t);
    localparam int TAG_W = 4;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: D-entry FIFO, FIFO order, push/pop/count/head.
// Ports: clk, rst (async active-low), push, pop, din -> head (oldest entry),
// count, vld (per-slot valid), tags (top TW bits of every slot).
// Callers must not push when full or pop when empty.
module wb_fifo #(
    parameter int W  = 21,
    parameter int D  = 2,
    parameter int TW = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic [$clog2(D+1)-1:0]     count,
    output logic [D-1:0]               vld,
    output logic [D-1:0][TW-1:0]       tags
);
    localparam int PW = (D > 1) ? $clog2(D) : 1;
    localparam int CW = $clog2(D + 1);
    logic [D-1:0][W-1:0] mem;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem    <= '0;
            vld    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= nxt(rd_ptr);
            end
            count <= push && !pop ? count + CW'(1) : !push && pop ? count - CW'(1) : count;
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        tags = '0;
        for (int i = 0; i < D; i++) tags[i] = mem[i][W-1 -: TW];
    end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: 2-deep retire queue feeding the register-file write port, with halt drain.
// Ports: clk, rst (async active-low); in_valid/in_ready handshake with in_wen, in_dst,
// in_sel, in_alu/in_mem/in_pc2/in_imm, in_halt; wb_hold freezes pops; outputs
// writeRegSel/writeData/writeEn, busy (pending-write scoreboard), retired, halted, err.
module writeback_unit
    import wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_wen,
    input  logic [2:0]  in_dst,
    input  logic [1:0]  in_sel,
    input  logic [15:0] in_alu,
    input  logic [15:0] in_mem,
    input  logic [15:0] in_pc2,
    input  logic [15:0] in_imm,
    input  logic        in_halt,
    input  logic        wb_hold,
    output logic [2:0]  writeRegSel,
    output logic [15:0] writeData,
    output logic        writeEn,
    output logic [7:0]  busy,
    output logic [15:0] retired,
    output logic        halted,
    output logic        err
);
    logic [1:0]                state;
    logic [CNT_W-1:0]          count;
    logic [DEPTH-1:0]          vld;
    logic [DEPTH-1:0][TAG_W-1:0] tags;
    logic [15:0]               sel_data;
    entry_t                    din;
    entry_t                    head;
    logic                      accept;
    logic                      pop;
    logic                      has;

    assign has      = count != '0;
    assign in_ready = state == ST_RUN && count < CNT_W'(DEPTH);
    assign accept   = in_valid && in_ready;
    assign pop      = has && !wb_hold;
    assign sel_data = in_sel == SEL_ALU ? in_alu :
                      in_sel == SEL_MEM ? in_mem :
                      in_sel == SEL_PC2 ? in_pc2 : in_imm;
    assign din      = '{wen: in_wen, dst: in_dst, data: sel_data, halt: in_halt};

    wb_fifo #(.W(ENTRY_W), .D(DEPTH), .TW(TAG_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .count (count),
        .vld   (vld),
        .tags  (tags)
    );

    assign writeEn     = pop && head.wen;
    assign writeRegSel = has ? head.dst : 3'd0;
    assign writeData   = has ? head.data : 16'd0;
    assign halted      = state == ST_HALTED;

    // tag = {wen, dst}
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) if (vld[i] && tags[i][3]) busy[tags[i][2:0]] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_RUN;
            retired <= '0;
            err     <= 1'b0;
        end else begin
            if (pop) retired <= retired + 16'd1;
            // only a full queue in RUN is a protocol error; DRAIN/HALTED silently drop
            if (in_valid && state == ST_RUN && count == CNT_W'(DEPTH)) err <= 1'b1;
            if (state == ST_RUN && accept && in_halt) state <= ST_DRAIN;
            else if (state == ST_DRAIN && pop && head.halt) state <= ST_HALTED;
        end
    end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: random + directed stimulus against a queue-based reference model
module tb_writeback_unit;
    logic        clk = 0;
    logic        rst;
    logic        in_valid, in_wen, in_halt, wb_hold;
    logic [2:0]  in_dst;
    logic [1:0]  in_sel;
    logic [15:0] in_alu, in_mem, in_pc2, in_imm;
    logic        in_ready, writeEn, halted, err;
    logic [2:0]  writeRegSel;
    logic [15:0] writeData, retired;
    logic [7:0]  busy;

    writeback_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
        .in_dst(in_dst), .in_sel(in_sel), .in_alu(in_alu), .in_mem(in_mem), .in_pc2(in_pc2),
        .in_imm(in_imm), .in_halt(in_halt), .wb_hold(wb_hold), .writeRegSel(writeRegSel),
        .writeData(writeData), .writeEn(writeEn), .busy(busy), .retired(retired),
        .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [2:0]  dst;
        logic [15:0] data;
        logic        halt;
    } ent_t;

    ent_t        q[$];
    int          m_st;
    logic [15:0] m_ret;
    logic        m_err;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 0;
        #1;
        check("rst_we", writeEn, 0);
        check("rst_busy", busy, 0);
        check("rst_ret", retired, 0);
        check("rst_err", err, 0);
        check("rst_halt", halted, 0);
        check("rst_rdy", in_ready, 1);
        check("rst_data", writeData, 0);
        check("rst_sel", writeRegSel, 0);
        q = {};
        m_st = 0;
        m_ret = 0;
        m_err = 0;
        @(negedge clk);
        rst = 1;
    endtask

    task automatic step(input logic v, input logic wen, input logic [2:0] dst, input logic [1:0] sel,
                        input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] pc2,
                        input logic [15:0] imm, input logic halt, input logic hold);
        logic        rdy, pop, we;
        logic [7:0]  b;
        ent_t        e;
        in_valid = v; in_wen = wen; in_dst = dst; in_sel = sel;
        in_alu = alu; in_mem = mem; in_pc2 = pc2; in_imm = imm;
        in_halt = halt; wb_hold = hold;
        #1;
        rdy = (m_st == 0) && (q.size() < 2);
        pop = (q.size() > 0) && !hold;
        we  = pop && q[0].wen;
        b = 0;
        foreach (q[i]) if (q[i].wen) b[q[i].dst] = 1'b1;
        check("ready", in_ready, rdy);
        check("we", writeEn, we);
        check("sel", writeRegSel, q.size() > 0 ? q[0].dst : 3'd0);
        check("data", writeData, q.size() > 0 ? q[0].data : 16'd0);
        check("busy", busy, b);
        check("retired", retired, m_ret);
        check("halted", halted, m_st == 2);
        check("err", err, m_err);
        if (v && !rdy && m_st == 0 && q.size() == 2) m_err = 1;
        if (pop) begin
            e = q.pop_front();
            m_ret++;
            if (e.halt) m_st = 2;
        end
        if (v && rdy) begin
            e.wen = wen; e.dst = dst; e.halt = halt;
            case (sel)
                2'b00: e.data = alu;
                2'b01: e.data = mem;
                2'b10: e.data = pc2;
                default: e.data = imm;
            endcase
            q.push_back(e);
            if (halt) m_st = 1;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic idle(input logic hold);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, hold);
    endtask

    initial begin
        rst = 0; in_valid = 0; in_wen = 0; in_halt = 0; wb_hold = 0;
        in_dst = 0; in_sel = 0; in_alu = 0; in_mem = 0; in_pc2 = 0; in_imm = 0;
        @(negedge clk);
        do_reset();
        idle(0);

        // single ALU write, one-cycle latency
        step(1, 1, 3, 2'b00, 16'h1234, 16'h5555, 16'h6666, 16'h7777, 0, 0);
        #1;
        check("d34_we", writeEn, 1);
        check("d34_sel", writeRegSel, 3);
        check("d34_data", writeData, 16'h1234);
        idle(0);
        #1;
        check("d34_ret", retired, 1);

        // hold fills the queue, overflow sets err, release drains in order
        step(1, 1, 1, 2'b00, 16'h0101, 0, 0, 0, 0, 1);
        step(1, 1, 5, 2'b00, 16'h0505, 0, 0, 0, 0, 1);
        #1;
        check("d35_rdy", in_ready, 0);
        check("d35_busy", busy, 8'b0010_0010);
        step(1, 1, 7, 2'b00, 16'h0707, 0, 0, 0, 0, 1);
        #1;
        check("d35_err", err, 1);
        idle(0);
        idle(0);
        idle(0);
        check("d35_ret", retired, 3);

        // MEM, PC+2 and IMM selects
        do_reset();
        step(1, 1, 2, 2'b01, 16'h0000, 16'hBEEF, 16'h1111, 16'h2222, 0, 0);
        #1;
        check("d36_mem", writeData, 16'hBEEF);
        step(1, 1, 4, 2'b10, 16'h0000, 16'h3333, 16'hCAFE, 16'h4444, 0, 0);
        #1;
        check("d36_pc2", writeData, 16'hCAFE);
        step(1, 1, 6, 2'b11, 16'h0000, 16'h5555, 16'h6666, 16'hF00D, 0, 0);
        #1;
        check("d36_imm", writeData, 16'hF00D);
        idle(0);

        // halt behind a pending write
        step(1, 1, 2, 2'b00, 16'hAAAA, 0, 0, 0, 0, 1);
        step(1, 0, 0, 2'b00, 16'h0000, 0, 0, 0, 1, 1);
        #1;
        check("d37_rdy", in_ready, 0);
        idle(0);
        idle(0);
        #1;
        check("d37_halted", halted, 1);
        step(1, 1, 1, 2'b00, 16'h9999, 0, 0, 0, 0, 0);
        step(1, 1, 1, 2'b00, 16'h9999, 0, 0, 0, 0, 0);
        step(1, 1, 1, 2'b00, 16'h9999, 0, 0, 0, 0, 0);
        #1;
        check("d37_err", err, 0);
        check("d37_we", writeEn, 0);

        // retired wrap
        do_reset();
        for (int i = 0; i < 65536; i++)
            step(1, 1'($urandom), 3'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom), 0, 0);
        #1;
        check("d38_ffff", retired, 16'hFFFF);
        idle(0);
        #1;
        check("d38_wrap", retired, 16'h0000);

        // reset mid-queue
        step(1, 1, 1, 2'b00, 16'h1111, 0, 0, 0, 0, 1);
        step(1, 1, 6, 2'b00, 16'h6666, 0, 0, 0, 0, 1);
        #2;
        do_reset();
        idle(0);

        // random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0 || (m_st == 2 && $urandom_range(0, 9) == 0))
                do_reset();
            else
                step($urandom_range(0, 3) != 0, 1'($urandom), 3'($urandom), 2'($urandom),
                     16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                     $urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
